mix_column_arbiter: RTL and testbench



---
 rtl/mix_column_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mix_column_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mix_column_arbiter.sv
// Shares one registered (1-cycle) MixColumns unit between the AES round engine
// and the aes32/aes64 mix-instruction path, with credit-checked response FIFOs.

module mix_column_rsp_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 128,
    parameter int CW    = $clog2(DEPTH + 2)
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic [CW-1:0]    count,
    output logic [CW-1:0]    count_next
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign valid      = (count != '0);
    assign pop        = valid && ready;
    assign data       = valid ? mem[rd_ptr] : '0;
    assign count_next = count + CW'(push) - CW'(pop);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            count <= count_next;
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
        end
    end

    // NOTE: storage is not reset; count gates valid and data, so stale
    // contents never reach the outputs.
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assert property (@(posedge clk_i) disable iff (!rst_n) !(push && count == CW'(DEPTH)));

endmodule

module mix_column_arbiter #(
    parameter int RSP_DEPTH   = 2,
    parameter int ROUND_ROBIN = 1
) (
    input  logic         clk_i,
    input  logic         rst_n,
    input  logic         req0_valid_i,
    input  logic [127:0] req0_data_i,
    output logic         req0_ready_o,
    output logic         rsp0_valid_o,
    output logic [127:0] rsp0_data_o,
    input  logic         rsp0_ready_i,
    input  logic         req1_valid_i,
    input  logic [127:0] req1_data_i,
    output logic         req1_ready_o,
    output logic         rsp1_valid_o,
    output logic [127:0] rsp1_data_o,
    input  logic         rsp1_ready_i,
    output logic         mix_en_o,
    output logic [127:0] mix_state_o,
    input  logic [127:0] mix_state_i,
    output logic         busy_o
);
    localparam int CW = $clog2(RSP_DEPTH + 2);

    logic [CW-1:0] count0, count1;
    logic [CW-1:0] count_next0, count_next1;
    logic [CW-1:0] credit0, credit1;
    logic          eligible0, eligible1;
    logic [1:0]    grant;
    logic          grant_id;
    logic          inflight_valid;
    logic          inflight_id;
    logic          last_id;
    logic          push0, push1;

    // A result reserves its FIFO slot from issue until the cycle after its pop.
    assign credit0   = count0 + CW'(inflight_valid && !inflight_id);
    assign credit1   = count1 + CW'(inflight_valid && inflight_id);
    assign eligible0 = req0_valid_i && (credit0 < CW'(RSP_DEPTH));
    assign eligible1 = req1_valid_i && (credit1 < CW'(RSP_DEPTH));

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        grant    = 2'b00;
        grant_id = 1'b0;
        if (rst_n) begin
            if (eligible0 && eligible1)
                grant_id = (ROUND_ROBIN != 0) ? ~last_id : 1'b0;
            else
                grant_id = eligible1;
            grant = {eligible1 && grant_id, eligible0 && !grant_id};
        end
    end

    assign req0_ready_o = grant[0];
    assign req1_ready_o = grant[1];
    assign mix_en_o     = |grant;
    assign mix_state_o  = grant[0] ? req0_data_i : (grant[1] ? req1_data_i : '0);

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            inflight_valid <= 1'b0;
            inflight_id    <= 1'b0;
            last_id        <= 1'b1;  // requester 0 wins the first contention
            busy_o         <= 1'b0;
        end else begin
            inflight_valid <= mix_en_o;
            inflight_id    <= grant_id;
            if (mix_en_o) last_id <= grant_id;
            busy_o <= mix_en_o || (count_next0 != '0) || (count_next1 != '0);
        end
    end

    assign push0 = inflight_valid && !inflight_id;
    assign push1 = inflight_valid && inflight_id;

    mix_column_rsp_fifo #(.DEPTH(RSP_DEPTH), .WIDTH(128), .CW(CW)) u_rsp0 (
        .clk_i      (clk_i),
        .rst_n      (rst_n),
        .push       (push0),
        .push_data  (mix_state_i),
        .ready      (rsp0_ready_i),
        .valid      (rsp0_valid_o),
        .data       (rsp0_data_o),
        .count      (count0),
        .count_next (count_next0)
    );

    mix_column_rsp_fifo #(.DEPTH(RSP_DEPTH), .WIDTH(128), .CW(CW)) u_rsp1 (
        .clk_i      (clk_i),
        .rst_n      (rst_n),
        .push       (push1),
        .push_data  (mix_state_i),
        .ready      (rsp1_ready_i),
        .valid      (rsp1_valid_o),
        .data       (rsp1_data_o),
        .count      (count1),
        .count_next (count_next1)
    );

endmodule

// File: tb/tb_mix_column_arbiter.sv
// Directed bench for mix_column_arbiter: a round-robin depth-2 instance and a
// fixed-priority depth-3 instance, each driving a registered MixColumns model.

module tb_mix_column_arbiter;
    localparam logic [127:0] D01     = {16{8'h01}};
    localparam logic [127:0] DFF     = {16{8'hff}};
    localparam logic [127:0] VEC_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] VEC_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;

    logic         clk_i = 1'b0;
    logic         rst_n;
    logic         req0_valid, req1_valid, req0_ready, req1_ready;
    logic [127:0] req0_data, req1_data;
    logic         rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
    logic [127:0] rsp0_data, rsp1_data;
    logic         mix_en, busy;
    logic [127:0] mix_state, mix_q;

    logic         fp_req0_valid, fp_req1_valid, fp_req0_ready, fp_req1_ready;
    logic [127:0] fp_req0_data, fp_req1_data;
    logic         fp_rsp0_valid, fp_rsp1_valid, fp_rsp0_ready, fp_rsp1_ready;
    logic [127:0] fp_rsp0_data, fp_rsp1_data;
    logic         fp_mix_en, fp_busy;
    logic [127:0] fp_mix_state, fp_mix_q;

    logic [31:0]  cyc = '0;
    logic         tag_mode = 1'b0;
    int           n_cmp = 0;
    int           n_err = 0;

    always #5 clk_i = ~clk_i;

    always_ff @(posedge clk_i) cyc <= cyc + 32'd1;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[c*32+24 +: 8];
            a1 = s[c*32+16 +: 8];
            a2 = s[c*32+8  +: 8];
            a3 = s[c*32    +: 8];
            r[c*32+24 +: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
            r[c*32+16 +: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
            r[c*32+8  +: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
            r[c*32    +: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
        return r;
    endfunction

    // Unit models: output is zero when not enabled; tag mode returns the issue cycle.
    always_ff @(posedge clk_i)
        mix_q <= !mix_en ? '0 : (tag_mode ? {96'h0, cyc} : mix_columns(mix_state));
    always_ff @(posedge clk_i)
        fp_mix_q <= !fp_mix_en ? '0 : mix_columns(fp_mix_state);

    mix_column_arbiter #(.RSP_DEPTH(2), .ROUND_ROBIN(1)) dut (
        .clk_i        (clk_i),
        .rst_n        (rst_n),
        .req0_valid_i (req0_valid),
        .req0_data_i  (req0_data),
        .req0_ready_o (req0_ready),
        .rsp0_valid_o (rsp0_valid),
        .rsp0_data_o  (rsp0_data),
        .rsp0_ready_i (rsp0_ready),
        .req1_valid_i (req1_valid),
        .req1_data_i  (req1_data),
        .req1_ready_o (req1_ready),
        .rsp1_valid_o (rsp1_valid),
        .rsp1_data_o  (rsp1_data),
        .rsp1_ready_i (rsp1_ready),
        .mix_en_o     (mix_en),
        .mix_state_o  (mix_state),
        .mix_state_i  (mix_q),
        .busy_o       (busy)
    );

    mix_column_arbiter #(.RSP_DEPTH(3), .ROUND_ROBIN(0)) dut_fp (
        .clk_i        (clk_i),
        .rst_n        (rst_n),
        .req0_valid_i (fp_req0_valid),
        .req0_data_i  (fp_req0_data),
        .req0_ready_o (fp_req0_ready),
        .rsp0_valid_o (fp_rsp0_valid),
        .rsp0_data_o  (fp_rsp0_data),
        .rsp0_ready_i (fp_rsp0_ready),
        .req1_valid_i (fp_req1_valid),
        .req1_data_i  (fp_req1_data),
        .req1_ready_o (fp_req1_ready),
        .rsp1_valid_o (fp_rsp1_valid),
        .rsp1_data_o  (fp_rsp1_data),
        .rsp1_ready_i (fp_rsp1_ready),
        .mix_en_o     (fp_mix_en),
        .mix_state_o  (fp_mix_state),
        .mix_state_i  (fp_mix_q),
        .busy_o       (fp_busy)
    );

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 0; req1_valid = 0; req0_data = '0; req1_data = '0;
        rsp0_ready = 0; rsp1_ready = 0;
        fp_req0_valid = 0; fp_req1_valid = 0; fp_req0_data = '0; fp_req1_data = '0;
        fp_rsp0_ready = 0; fp_rsp1_ready = 0;
        tag_mode = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        step();
        step();
        rst_n = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        req0_valid = 1; req0_data = DFF; req1_valid = 1; req1_data = D01;
        step();
        step();
        #2;
        n_cmp++; if (req0_ready !== 1'b0) begin n_err++; $display("FAIL reset_req0_ready: got %b want 0", req0_ready); end
        n_cmp++; if (req1_ready !== 1'b0) begin n_err++; $display("FAIL reset_req1_ready: got %b want 0", req1_ready); end
        n_cmp++; if (mix_en !== 1'b0) begin n_err++; $display("FAIL reset_mix_en: got %b want 0", mix_en); end
        n_cmp++; if (mix_state !== '0) begin n_err++; $display("FAIL reset_mix_state: got %h want 0", mix_state); end
        n_cmp++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %b%b want 00", rsp1_valid, rsp0_valid); end
        n_cmp++; if (rsp0_data !== '0 || rsp1_data !== '0) begin n_err++; $display("FAIL reset_rsp_data: got %h / %h want 0", rsp0_data, rsp1_data); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        idle_inputs();
        rst_n = 1;
        step();
    endtask

    task automatic test_single();
        do_reset();
        req0_valid = 1; req0_data = D01;
        #2;
        n_cmp++; if (req0_ready !== 1'b1) begin n_err++; $display("FAIL single_ready0: got %b want 1", req0_ready); end
        n_cmp++; if (mix_en !== 1'b1) begin n_err++; $display("FAIL single_mix_en: got %b want 1", mix_en); end
        n_cmp++; if (mix_state !== D01) begin n_err++; $display("FAIL single_mix_state: got %h want %h", mix_state, D01); end
        n_cmp++; if (req1_ready !== 1'b0) begin n_err++; $display("FAIL single_ready1: got %b want 0", req1_ready); end
        step();
        req0_valid = 0;
        #2;
        n_cmp++; if (rsp0_valid !== 1'b0) begin n_err++; $display("FAIL single_rsp0_early: got %b want 0", rsp0_valid); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy_inflight: got %b want 1", busy); end
        step();
        #2;
        n_cmp++; if (rsp0_valid !== 1'b1) begin n_err++; $display("FAIL single_rsp0_valid: got %b want 1", rsp0_valid); end
        n_cmp++; if (rsp0_data !== D01) begin n_err++; $display("FAIL single_rsp0_data: got %h want %h", rsp0_data, D01); end
        n_cmp++; if (rsp1_valid !== 1'b0) begin n_err++; $display("FAIL single_rsp1_valid: got %b want 0", rsp1_valid); end
        rsp0_ready = 1;
        step();
        rsp0_ready = 0;
        #2;
        n_cmp++; if (rsp0_valid !== 1'b0) begin n_err++; $display("FAIL single_popped: got %b want 0", rsp0_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy_idle: got %b want 0", busy); end
    endtask

    task automatic test_mix_vector();
        do_reset();
        req1_valid = 1; req1_data = VEC_IN;
        #2;
        n_cmp++; if (req1_ready !== 1'b1) begin n_err++; $display("FAIL vec_ready1: got %b want 1", req1_ready); end
        step();
        req1_valid = 0;
        step();
        #2;
        n_cmp++; if (rsp1_valid !== 1'b1 || rsp1_data !== VEC_OUT) begin n_err++; $display("FAIL vec_rsp1: got %b %h want 1 %h", rsp1_valid, rsp1_data, VEC_OUT); end
        n_cmp++; if (rsp0_valid !== 1'b0) begin n_err++; $display("FAIL vec_rsp0_valid: got %b want 0", rsp0_valid); end
        rsp1_ready = 1;
        step();
        rsp1_ready = 0;
    endtask

    task automatic test_round_robin();
        logic exp0;
        do_reset();
        req0_valid = 1; req0_data = DFF; req1_valid = 1; req1_data = D01;
        rsp0_ready = 1; rsp1_ready = 1;
        for (int i = 0; i < 8; i++) begin
            exp0 = (i % 2 == 0);
            #2;
            n_cmp++; if (req0_ready !== exp0 || req1_ready !== !exp0) begin n_err++; $display("FAIL rr_grant[%0d]: got %b%b want %b%b", i, req1_ready, req0_ready, !exp0, exp0); end
            if (i >= 2) begin
                n_cmp++; if (rsp0_valid !== exp0 || rsp1_valid !== !exp0) begin n_err++; $display("FAIL rr_rsp_valid[%0d]: got %b%b want %b%b", i, rsp1_valid, rsp0_valid, !exp0, exp0); end
                n_cmp++; if ((exp0 ? rsp0_data : rsp1_data) !== (exp0 ? DFF : D01)) begin n_err++; $display("FAIL rr_rsp_data[%0d]: got %h want %h", i, exp0 ? rsp0_data : rsp1_data, exp0 ? DFF : D01); end
            end
            step();
        end
        req0_valid = 0; req1_valid = 0;
        repeat (3) step();
        rsp0_ready = 0; rsp1_ready = 0;
    endtask

    task automatic test_fixed_priority();
        do_reset();
        fp_req0_valid = 1; fp_req0_data = DFF; fp_req1_valid = 1; fp_req1_data = D01;
        fp_rsp0_ready = 1; fp_rsp1_ready = 1;
        for (int i = 0; i < 6; i++) begin
            #2;
            n_cmp++; if (fp_req0_ready !== 1'b1 || fp_req1_ready !== 1'b0) begin n_err++; $display("FAIL fp_grant[%0d]: got %b%b want 01", i, fp_req1_ready, fp_req0_ready); end
            if (i >= 2) begin
                n_cmp++; if (fp_rsp0_valid !== 1'b1 || fp_rsp0_data !== DFF || fp_rsp1_valid !== 1'b0) begin n_err++; $display("FAIL fp_rsp[%0d]: got %b %h %b want 1 %h 0", i, fp_rsp0_valid, fp_rsp0_data, fp_rsp1_valid, DFF); end
            end
            step();
        end
        fp_req0_valid = 0; fp_req1_valid = 0;
        repeat (3) step();
        fp_rsp0_ready = 0; fp_rsp1_ready = 0;
    endtask

    task automatic test_backpressure();
        // Per-cycle grants for C0..C7; req1 skips C4 because one result is in
        // flight and one is captured but not yet freed by a pop.
        logic [7:0]  e0 = 8'b0100_0011;
        logic [7:0]  e1 = 8'b1010_1100;
        logic [31:0] t0, t1, t6, t10, exp_head;
        int          grants0;
        t0 = '0; t1 = '0; t6 = '0; t10 = '0; grants0 = 0;
        do_reset();
        tag_mode = 1;
        rsp1_ready = 1;
        for (int i = 0; i < 8; i++) begin
            req0_valid = 1;
            req1_valid = (i >= 2);
            rsp0_ready = (i == 5);
            #2;
            n_cmp++; if (req0_ready !== e0[i] || req1_ready !== e1[i]) begin n_err++; $display("FAIL bp_grant[%0d]: got %b%b want %b%b", i, req1_ready, req0_ready, e1[i], e0[i]); end
            if (i < 5 && req0_ready === 1'b1) grants0++;
            if (i == 0) t0 = cyc;
            if (i == 1) t1 = cyc;
            if (i == 6) t6 = cyc;
            if (i >= 2) begin
                exp_head = (i < 6) ? t0 : t1;
                n_cmp++; if (rsp0_valid !== 1'b1 || rsp0_data !== {96'h0, exp_head}) begin n_err++; $display("FAIL bp_head[%0d]: got %b %h want 1 %h", i, rsp0_valid, rsp0_data[31:0], exp_head); end
            end else begin
                n_cmp++; if (rsp0_valid !== 1'b0) begin n_err++; $display("FAIL bp_head_early[%0d]: got %b want 0", i, rsp0_valid); end
            end
            step();
        end
        n_cmp++; if (grants0 !== 2) begin n_err++; $display("FAIL bp_grant_count: got %0d want 2", grants0); end
        req0_valid = 0; req1_valid = 0; rsp0_ready = 0;
        #2;
        n_cmp++; if (rsp0_data !== {96'h0, t1} || busy !== 1'b1) begin n_err++; $display("FAIL bp_full_head: got %h busy %b want %h busy 1", rsp0_data[31:0], busy, t1); end
        step();
        rsp0_ready = 1; req0_valid = 1;
        #2;
        n_cmp++; if (req0_ready !== 1'b0) begin n_err++; $display("FAIL bp_full_no_grant: got %b want 0", req0_ready); end
        step();
        rsp0_ready = 0;
        #2;
        n_cmp++; if (req0_ready !== 1'b1 || rsp0_data !== {96'h0, t6}) begin n_err++; $display("FAIL bp_regrant: got %b %h want 1 %h", req0_ready, rsp0_data[31:0], t6); end
        t10 = cyc;
        step();
        req0_valid = 0; rsp0_ready = 1;
        #2;
        n_cmp++; if (rsp0_valid !== 1'b1 || rsp0_data !== {96'h0, t6}) begin n_err++; $display("FAIL bp_pushpop_head: got %b %h want 1 %h", rsp0_valid, rsp0_data[31:0], t6); end
        step();
        #2;
        n_cmp++; if (rsp0_valid !== 1'b1 || rsp0_data !== {96'h0, t10}) begin n_err++; $display("FAIL bp_pushpop_next: got %b %h want 1 %h", rsp0_valid, rsp0_data[31:0], t10); end
        step();
        rsp0_ready = 0;
        #2;
        n_cmp++; if (rsp0_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL bp_drained: got valid %b busy %b want 0 0", rsp0_valid, busy); end
        tag_mode = 0;
        rsp1_ready = 0;
    endtask

    task automatic test_tag_routing();
        logic [31:0] ta, tb;
        do_reset();
        tag_mode = 1;
        req1_valid = 1;
        #2;
        n_cmp++; if (req1_ready !== 1'b1) begin n_err++; $display("FAIL tag_grant1: got %b want 1", req1_ready); end
        ta = cyc;
        step();
        req1_valid = 0; req0_valid = 1;
        #2;
        n_cmp++; if (req0_ready !== 1'b1) begin n_err++; $display("FAIL tag_grant0: got %b want 1", req0_ready); end
        n_cmp++; if (rsp1_valid !== 1'b0) begin n_err++; $display("FAIL tag_rsp1_early: got %b want 0", rsp1_valid); end
        tb = cyc;
        step();
        req0_valid = 0;
        #2;
        n_cmp++; if (rsp1_valid !== 1'b1 || rsp1_data !== {96'h0, ta}) begin n_err++; $display("FAIL tag_rsp1: got %b %h want 1 %h", rsp1_valid, rsp1_data[31:0], ta); end
        n_cmp++; if (rsp0_valid !== 1'b0) begin n_err++; $display("FAIL tag_rsp0_early: got %b want 0", rsp0_valid); end
        step();
        #2;
        n_cmp++; if (rsp0_valid !== 1'b1 || rsp0_data !== {96'h0, tb}) begin n_err++; $display("FAIL tag_rsp0: got %b %h want 1 %h", rsp0_valid, rsp0_data[31:0], tb); end
        n_cmp++; if (rsp1_data !== {96'h0, ta}) begin n_err++; $display("FAIL tag_rsp1_hold: got %h want %h", rsp1_data[31:0], ta); end
        rsp0_ready = 1; rsp1_ready = 1;
        step();
        rsp0_ready = 0; rsp1_ready = 0;
        #2;
        n_cmp++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL tag_drained: got %b%b busy %b want 00 busy 0", rsp1_valid, rsp0_valid, busy); end
        tag_mode = 0;
    endtask

    task automatic test_reset_midflight();
        do_reset();
        req1_valid = 1; req1_data = D01;
        #2;
        n_cmp++; if (req1_ready !== 1'b1) begin n_err++; $display("FAIL mid_grant_a: got %b want 1", req1_ready); end
        step();
        #2;
        n_cmp++; if (req1_ready !== 1'b1) begin n_err++; $display("FAIL mid_grant_b: got %b want 1", req1_ready); end
        step();
        req1_valid = 0;
        #2;
        n_cmp++; if (rsp1_valid !== 1'b1 || busy !== 1'b1) begin n_err++; $display("FAIL mid_pre_reset: got valid %b busy %b want 1 1", rsp1_valid, busy); end
        rst_n = 0; req0_valid = 1; req0_data = DFF;
        #1;
        n_cmp++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin n_err++; $display("FAIL mid_rsp_valid: got %b%b want 00", rsp1_valid, rsp0_valid); end
        n_cmp++; if (mix_en !== 1'b0 || busy !== 1'b0 || req0_ready !== 1'b0) begin n_err++; $display("FAIL mid_outputs: got en %b busy %b rdy %b want 0 0 0", mix_en, busy, req0_ready); end
        step();
        step();
        rst_n = 1;
        #2;
        n_cmp++; if (req0_ready !== 1'b1 || mix_en !== 1'b1) begin n_err++; $display("FAIL mid_post_grant: got rdy %b en %b want 1 1", req0_ready, mix_en); end
        step();
        req0_valid = 0;
        #2;
        n_cmp++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin n_err++; $display("FAIL mid_no_stale: got %b%b want 00", rsp1_valid, rsp0_valid); end
        step();
        #2;
        n_cmp++; if (rsp0_valid !== 1'b1 || rsp0_data !== DFF || rsp1_valid !== 1'b0) begin n_err++; $display("FAIL mid_post_rsp: got %b %h %b want 1 %h 0", rsp0_valid, rsp0_data, rsp1_valid, DFF); end
        rsp0_ready = 1;
        step();
        rsp0_ready = 0;
    endtask

    initial begin
        idle_inputs();
        rst_n = 0;
        test_reset();
        test_single();
        test_mix_vector();
        test_round_robin();
        test_fixed_priority();
        test_backpressure();
        test_tag_routing();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
